// File: rtl/vc32_mem_pkg.sv
// Shared types and constants for the dcache <-> quad-nibble serial memory sequencer.
package vc32_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WAIT,
        DATA,
        GAP
    } state_e;

    localparam logic [7:0] CMD_RD_DEF = 8'hEB;
    localparam logic [7:0] CMD_WR_DEF = 8'h38;

    // Number of address nibbles needed to carry a pa-bit physical address.
    function automatic int unsigned nib_count(input int unsigned pa);
        return (pa + 3) / 4;
    endfunction

endpackage

// File: rtl/dcache_mem_ctl.sv
// Line-transfer sequencer: one write-back or line fill per miss over a quad-nibble serial
// memory, streaming line nibbles to/from the dcache through strobed nibble ports.
module dcache_mem_ctl
    import vc32_mem_pkg::*;
#(
    parameter int unsigned PA          = 22,
    parameter int unsigned LINE_LENGTH = 4,
    parameter logic [7:0]  CMD_RD      = CMD_RD_DEF,
    parameter logic [7:0]  CMD_WR      = CMD_WR_DEF,
    parameter int unsigned READ_WAIT   = 6,
    parameter int unsigned CS_GAP      = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          hit,
    input  logic          push,
    input  logic          pull,
    input  logic [PA-3:0] tag,
    input  logic [3:0]    dwrite,
    output logic          rstrobe_d,
    output logic          wstrobe_d,
    output logic [3:0]    dread,
    output logic          busy,
    output logic          done,
    output logic          mem_sel,
    output logic          mem_oe,
    output logic [3:0]    mem_dout,
    input  logic [3:0]    mem_din
);

    localparam int unsigned NIB = nib_count(PA);
    localparam int unsigned AW  = 4 * NIB;

    localparam logic [4:0] CMD_LAST  = 5'd1;
    localparam logic [4:0] ADDR_LAST = 5'(NIB - 1);
    localparam logic [4:0] WAIT_LAST = 5'(READ_WAIT - 1);
    localparam logic [4:0] DATA_LAST = 5'(2 * LINE_LENGTH - 1);
    localparam logic [4:0] GAP_LAST  = 5'(CS_GAP - 1);

    state_e        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          op_wr_q, op_wr_d;
    logic [AW-1:0] addr_q, addr_d;

    logic       start;
    logic       can_start;
    logic       cnt_zero;
    logic [7:0] cmd_byte;

    assign start     = req && !hit && (push || pull);
    assign cnt_zero  = (cnt_q == 5'd0);
    // The last GAP cycle already satisfies the chip-select gap, so a queued miss starts there.
    assign can_start = (state_q == IDLE) || ((state_q == GAP) && cnt_zero);
    assign cmd_byte  = op_wr_q ? CMD_WR : CMD_RD;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: ;
            CMD: begin
                if (cnt_zero) begin
                    state_d = ADDR;
                    cnt_d   = ADDR_LAST;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ADDR: begin
                addr_d = addr_q << 4;
                if (cnt_zero) begin
                    state_d = op_wr_q ? DATA : WAIT;
                    cnt_d   = op_wr_q ? DATA_LAST : WAIT_LAST;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    state_d = DATA;
                    cnt_d   = DATA_LAST;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    state_d = GAP;
                    cnt_d   = GAP_LAST;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (can_start && start) begin
            state_d = CMD;
            cnt_d   = CMD_LAST;
            op_wr_d = push;
            addr_d  = AW'({tag, 2'b00});
        end
    end

    always_comb begin
        rstrobe_d = 1'b0;
        wstrobe_d = 1'b0;
        dread     = 4'h0;
        done      = 1'b0;
        mem_sel   = 1'b0;
        mem_oe    = 1'b0;
        mem_dout  = 4'h0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            CMD: begin
                mem_sel  = 1'b1;
                mem_oe   = 1'b1;
                mem_dout = cnt_q[0] ? cmd_byte[7:4] : cmd_byte[3:0];
            end
            ADDR: begin
                mem_sel  = 1'b1;
                mem_oe   = 1'b1;
                mem_dout = addr_q[AW-1 -: 4];
            end
            WAIT: mem_sel = 1'b1;
            DATA: begin
                mem_sel = 1'b1;
                done    = cnt_zero;
                if (op_wr_q) begin
                    rstrobe_d = 1'b1;
                    mem_oe    = 1'b1;
                    mem_dout  = dwrite;
                end else begin
                    wstrobe_d = 1'b1;
                    dread     = mem_din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_dcache_mem_ctl.sv
// Directed bench for dcache_mem_ctl: fills, write-backs, back-to-back misses, aborts by reset,
// and chip-select gap length with a second instance built for a 3-cycle gap.
module tb_dcache_mem_ctl;

    logic        clk = 1'b0;
    logic        reset, req, hit, push, pull;
    logic [19:0] tag;
    logic [3:0]  dwrite, mem_din;

    logic       rstrobe_d, wstrobe_d, busy, done, mem_sel, mem_oe;
    logic [3:0] dread, mem_dout;
    logic       rstrobe_d2, wstrobe_d2, busy2, done2, mem_sel2, mem_oe2;
    logic [3:0] dread2, mem_dout2;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] r_dout[0:63];
    logic [3:0] r_dread[0:63];
    logic       r_sel[0:63], r_oe[0:63], r_rs[0:63], r_ws[0:63];
    logic       r_done[0:63], r_busy[0:63], r_sel2[0:63];

    always #5 clk = ~clk;

    dcache_mem_ctl dut (
        .clk(clk), .reset(reset), .req(req), .hit(hit), .push(push), .pull(pull), .tag(tag),
        .dwrite(dwrite), .rstrobe_d(rstrobe_d), .wstrobe_d(wstrobe_d), .dread(dread),
        .busy(busy), .done(done), .mem_sel(mem_sel), .mem_oe(mem_oe), .mem_dout(mem_dout),
        .mem_din(mem_din)
    );

    dcache_mem_ctl #(.CS_GAP(3)) dut_gap3 (
        .clk(clk), .reset(reset), .req(req), .hit(hit), .push(push), .pull(pull), .tag(tag),
        .dwrite(dwrite), .rstrobe_d(rstrobe_d2), .wstrobe_d(wstrobe_d2), .dread(dread2),
        .busy(busy2), .done(done2), .mem_sel(mem_sel2), .mem_oe(mem_oe2), .mem_dout(mem_dout2),
        .mem_din(mem_din)
    );

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int k);
        #1;
        r_dout[k]  = mem_dout;
        r_dread[k] = dread;
        r_sel[k]   = mem_sel;
        r_oe[k]    = mem_oe;
        r_rs[k]    = rstrobe_d;
        r_ws[k]    = wstrobe_d;
        r_done[k]  = done;
        r_busy[k]  = busy;
        r_sel2[k]  = mem_sel2;
    endtask

    // 0 sel, 1 oe, 2 rstrobe, 3 wstrobe, 4 busy, 5 done, 6 sel of the CS_GAP=3 instance
    function automatic int count_ones(input int which, input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) begin
            case (which)
                0:       n += int'(r_sel[i]);
                1:       n += int'(r_oe[i]);
                2:       n += int'(r_rs[i]);
                3:       n += int'(r_ws[i]);
                4:       n += int'(r_busy[i]);
                5:       n += int'(r_done[i]);
                default: n += int'(r_sel2[i]);
            endcase
        end
        return n;
    endfunction

    function automatic logic [31:0] pack8(input int a, input bit use_dread);
        logic [31:0] w = '0;
        for (int i = a; i < a + 8; i++) w = {w[27:0], use_dread ? r_dread[i] : r_dout[i]};
        return w;
    endfunction

    function automatic int first_done(input int a, input int b);
        for (int i = a; i <= b; i++) if (r_done[i]) return i;
        return -1;
    endfunction

    // Fill starting this cycle; memory returns the line nibbles in DATA (cycles 15..22).
    task automatic run_rd(input logic [19:0] t, input logic [31:0] line);
        req = 1'b1; hit = 1'b0; push = 1'b0; pull = 1'b1; tag = t;
        for (int k = 0; k < 25; k++) begin
            if (k == 1) begin req = 1'b0; pull = 1'b0; end
            mem_din = (k >= 15 && k <= 22) ? line[31 - 4 * (k - 15) -: 4] : 4'h0;
            sample(k);
            tick();
        end
        mem_din = 4'h0;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; hit = 1'b0; push = 1'b0; pull = 1'b0;
        tag = '0; dwrite = '0; mem_din = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("reset_outputs",
                 {22'd0, busy, mem_sel, mem_oe, rstrobe_d, wstrobe_d, done, mem_dout, dread},
                 32'h0);
        check_eq("reset_outputs_gap3", {30'd0, busy2, mem_sel2}, 32'h0);

        // 1: line fill, tag ABCDE -> address 0x2AF378
        run_rd(20'hABCDE, 32'h12345678);
        check_eq("t1_cmd_addr", pack8(1, 1'b0), 32'hEB2AF378);
        check_eq("t1_line", pack8(15, 1'b1), 32'h12345678);
        check_eq("t1_wstrobe_total", count_ones(3, 0, 24), 8);
        check_eq("t1_wstrobe_window", count_ones(3, 15, 22), 8);
        check_eq("t1_done_cycle", first_done(0, 24), 22);
        check_eq("t1_done_count", count_ones(5, 0, 24), 1);
        check_eq("t1_busy_edges", {29'd0, r_busy[0], r_busy[1], r_busy[24]}, 32'h2);
        check_eq("t1_gap_cycle", {30'd0, r_busy[23], r_sel[23]}, 32'h2);
        check_eq("t1_oe_cmd_addr", count_ones(1, 1, 8), 8);
        check_eq("t1_oe_wait_data", count_ones(1, 9, 24), 0);

        // 2: write-back, then the fill presented behind it
        for (int k = 0; k < 42; k++) begin
            if (k == 0) begin req = 1'b1; push = 1'b1; pull = 1'b0; tag = 20'h12345; end
            if (k == 1) begin push = 1'b0; pull = 1'b1; end
            if (k == 18) begin req = 1'b0; pull = 1'b0; end
            dwrite  = 4'(k + 3);
            mem_din = 4'(k);
            sample(k);
            tick();
        end
        check_eq("t2_rstrobe_total", count_ones(2, 0, 41), 8);
        check_eq("t2_rstrobe_window", count_ones(2, 9, 16), 8);
        check_eq("t2_wr_data", pack8(9, 1'b0), 32'hCDEF0123);
        check_eq("t2_sel_around_gap", {29'd0, r_sel[16], r_sel[17], r_sel[18]}, 32'h5);
        check_eq("t2_rd_cmd", {24'd0, r_dout[18], r_dout[19]}, 32'hEB);
        check_eq("t2_oe_rd_wait_data", count_ones(1, 26, 39), 0);
        check_eq("t2_wstrobe_window", count_ones(3, 32, 39), 8);
        check_eq("t2_rd_line", pack8(32, 1'b1), 32'h01234567);
        check_eq("t2_done_count", count_ones(5, 0, 41), 2);

        // 3: push and pull both set -> write; then a hit must not start anything
        for (int k = 0; k < 18; k++) begin
            if (k == 0) begin req = 1'b1; push = 1'b1; pull = 1'b1; tag = 20'h00001; end
            if (k == 1) begin req = 1'b0; push = 1'b0; pull = 1'b0; end
            sample(k);
            tick();
        end
        check_eq("t3_cmd_write", {24'd0, r_dout[1], r_dout[2]}, 32'h38);
        check_eq("t3_rstrobe", count_ones(2, 0, 17), 8);
        for (int k = 0; k < 4; k++) begin
            req = 1'b1; hit = 1'b1; pull = 1'b1;
            sample(k);
            tick();
        end
        req = 1'b0; hit = 1'b0; pull = 1'b0;
        check_eq("t3_hit_busy", count_ones(4, 0, 3), 0);
        check_eq("t3_hit_sel", count_ones(0, 0, 3), 0);

        // 4: req dropped in the second ADDR cycle, re-raised with pull low
        for (int k = 0; k < 31; k++) begin
            if (k == 0) begin req = 1'b1; pull = 1'b1; tag = 20'h54321; end
            if (k == 1) pull = 1'b0;
            if (k == 4) req = 1'b0;
            if (k == 23) req = 1'b1;
            sample(k);
            tick();
        end
        req = 1'b0;
        check_eq("t4_done_cycle", first_done(0, 30), 22);
        check_eq("t4_busy_during", count_ones(4, 1, 23), 23);
        check_eq("t4_no_restart", count_ones(4, 24, 30), 0);

        // 5: reset in DATA cycle 4 of a fill, then a clean re-fetch
        for (int k = 0; k < 20; k++) begin
            if (k == 0) begin req = 1'b1; pull = 1'b1; tag = 20'h3C3C3; end
            if (k == 1) begin req = 1'b0; pull = 1'b0; end
            if (k == 18) reset = 1'b1;
            mem_din = 4'hF;
            sample(k);
            tick();
        end
        check_eq("t5_in_data", {31'd0, r_ws[18]}, 32'h1);
        check_eq("t5_after_reset",
                 {22'd0, r_busy[19], r_sel[19], r_oe[19], r_rs[19], r_ws[19], r_done[19],
                  r_dout[19], r_dread[19]}, 32'h0);
        reset = 1'b0;
        mem_din = 4'h0;
        run_rd(20'hFEDCB, 32'h9A5C3E71);
        check_eq("t5_refetch_addr", pack8(1, 1'b0), 32'hEB3FB72C);
        check_eq("t5_refetch_line", pack8(15, 1'b1), 32'h9A5C3E71);
        check_eq("t5_refetch_done", first_done(0, 24), 22);
        for (int k = 0; k < 4; k++) tick();

        // 6: back-to-back misses on both instances (CS_GAP 1 and 3)
        for (int k = 0; k < 31; k++) begin
            if (k == 0) begin req = 1'b1; push = 1'b1; pull = 1'b0; tag = 20'h0F0F0; end
            if (k == 1) begin push = 1'b0; pull = 1'b1; end
            if (k == 21) begin req = 1'b0; pull = 1'b0; end
            sample(k);
            tick();
        end
        check_eq("t6_gap1_low", 25 - count_ones(0, 1, 25), 1);
        check_eq("t6_gap3_low", 25 - count_ones(6, 1, 25), 3);
        check_eq("t6_gap3_edges", {30'd0, r_sel2[16], r_sel2[20]}, 32'h3);
        for (int k = 0; k < 30; k++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
